// File: rtl/teclado_pkg.sv
// Shared types and constants for the keypad scanner.
// Used by module_teclado_scan and its optional row synchronizer.
package teclado_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESS,
      WAIT_RELEASE
   } teclado_state_t;

   localparam int         NUM_COLS   = 4;
   localparam int         NUM_ROWS   = 4;
   localparam logic [3:0] FILAS_IDLE = 4'b1111;
   localparam logic [3:0] COL_RESET  = 4'b1110;

   // A press is only meaningful when exactly one row conducts.
   function automatic logic single_row_low(input logic [3:0] filas);
      case (filas)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: single_row_low = 1'b1;
         default:                            single_row_low = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] filas);
      case (filas)
         4'b1101: row_index = 2'd1;
         4'b1011: row_index = 2'd2;
         4'b0111: row_index = 2'd3;
         default: row_index = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/module_teclado_scan_if.sv
// Keypad-side and data-side signals of the scanner.
// master = scanner, slave = keypad/consumer side.
interface module_teclado_scan_if;
   logic [3:0] filas_i;
   logic [3:0] columnas_o;
   logic [1:0] dato_codc_o;
   logic [1:0] dato_codf_o;
   logic       dato_listo_o;

   modport master (
      input  filas_i,
      output columnas_o, dato_codc_o, dato_codf_o, dato_listo_o
   );

   modport slave (
      output filas_i,
      input  columnas_o, dato_codc_o, dato_codf_o, dato_listo_o
   );
endinterface

// File: rtl/module_sync_2ff.sv
// Two-flop synchronizer for asynchronous keypad rows.
// Instantiated by module_teclado_scan only when TECLADO_SYNC_EN is defined.
module module_sync_2ff #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/module_teclado_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and one-cycle data pulse.
// Optional macro TECLADO_SYNC_EN adds a 2-flop synchronizer on the rows.
module module_teclado_scan
   import teclado_pkg::*;
#(
   parameter int SCAN_CYCLES     = 1000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   module_teclado_scan_if.master kp
);

   localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

   logic [3:0] filas_s;

`ifdef TECLADO_SYNC_EN
   module_sync_2ff #(
      .WIDTH   (NUM_ROWS),
      .RST_VAL (FILAS_IDLE)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (kp.filas_i),
      .q_o (filas_s)
   );
`else
   assign filas_s = kp.filas_i;
`endif

   teclado_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       columnas_q, columnas_d;
   logic [1:0]       codc_q, codc_d;
   logic [1:0]       codf_q, codf_d;
   logic             listo_q, listo_d;
   logic [3:0]       latched_pat;

   assign cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
   assign latched_pat = ~(4'b0001 << row_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      codc_d  = codc_q;
      codf_d  = codf_q;
      listo_d = 1'b0;

      case (state_q)
         SCAN: begin
            if (cnt_q >= SCAN_LAST) begin
               cnt_d = '0;
               if (single_row_low(filas_s)) begin
                  row_d   = row_index(filas_s);
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DEBOUNCE: begin
            if (filas_s != latched_pat) begin
               state_d = SCAN;
               cnt_d   = '0;
            end else if (cnt_q >= DEB_LAST) begin
               // Codes and pulse are registered on entry so they are valid during PRESS.
               state_d = PRESS;
               cnt_d   = '0;
               codc_d  = col_q;
               codf_d  = row_q;
               listo_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         PRESS: begin
            state_d = WAIT_RELEASE;
            cnt_d   = '0;
         end
         WAIT_RELEASE: begin
            if (filas_s != FILAS_IDLE) begin
               cnt_d = '0;
            end else if (cnt_q >= DEB_LAST) begin
               state_d = SCAN;
               cnt_d   = '0;
               col_d   = col_q + 2'd1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase

      columnas_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= SCAN;
         cnt_q      <= '0;
         col_q      <= 2'd0;
         row_q      <= 2'd0;
         columnas_q <= COL_RESET;
         codc_q     <= 2'd0;
         codf_q     <= 2'd0;
         listo_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         col_q      <= col_d;
         row_q      <= row_d;
         columnas_q <= columnas_d;
         codc_q     <= codc_d;
         codf_q     <= codf_d;
         listo_q    <= listo_d;
      end
   end

   assign kp.columnas_o   = columnas_q;
   assign kp.dato_codc_o  = codc_q;
   assign kp.dato_codf_o  = codf_q;
   assign kp.dato_listo_o = listo_q;

endmodule

// File: tb/tb_module_teclado_scan.sv
// Bench for module_teclado_scan: a 4x4 keypad matrix model drives the rows from the
// driven column; directed scenarios plus random single/multi-key presses.
module tb_module_teclado_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] keys;          // keys[c*4+r] = key at column c, row r held down
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          pulse_cnt = 0;
   int          pulse_cyc = -1;
   logic [1:0]  pulse_codc, pulse_codf;
   logic [1:0]  prev_codc = 2'd0, prev_codf = 2'd0;
   int          glitch_cnt = 0;

   module_teclado_scan_if ifc ();

   module_teclado_scan #(
      .SCAN_CYCLES     (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (ifc)
   );

   always #5 clk = ~clk;

   // Keypad physics: a pressed key pulls its row low only while its column is driven low.
   always_comb begin
      ifc.filas_i = 4'b1111;
      for (int c = 0; c < 4; c++)
         if (!ifc.columnas_o[c])
            for (int r = 0; r < 4; r++)
               if (keys[c*4+r]) ifc.filas_i[r] = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (ifc.dato_listo_o) begin
         pulse_cnt  = pulse_cnt + 1;
         pulse_cyc  = cyc;
         pulse_codc = ifc.dato_codc_o;
         pulse_codf = ifc.dato_codf_o;
      end else if (rst && (ifc.dato_codc_o != prev_codc || ifc.dato_codf_o != prev_codf)) begin
         glitch_cnt = glitch_cnt + 1;
      end
      prev_codc = ifc.dato_codc_o;
      prev_codf = ifc.dato_codf_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_col(input logic [3:0] v, input int budget, input string tag, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (ifc.columnas_o === v) begin
            at = cyc;
            break;
         end
      end
      chk(tag, 32'(at >= 0), 32'd1);
   endtask

   task automatic wait_pulse(input int prev, input int budget, input string tag);
      int k = 0;
      while (pulse_cnt == prev && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(pulse_cnt != prev), 32'd1);
   endtask

   initial begin
      int n, n0, n1, exp_pulses;
      int c, r, r2;
      logic [3:0] walk [4];

      rst  = 1'b0;
      keys = '0;
      exp_pulses = 0;
      walk[0] = 4'b1101; walk[1] = 4'b1011; walk[2] = 4'b0111; walk[3] = 4'b1110;

      // Reset state, then the idle column walk.
      repeat (3) @(negedge clk);
      chk("rst_columnas", ifc.columnas_o, 4'b1110);
      chk("rst_codc", ifc.dato_codc_o, 2'd0);
      chk("rst_codf", ifc.dato_codf_o, 2'd0);
      chk("rst_listo", ifc.dato_listo_o, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         repeat (4) @(negedge clk);
         chk($sformatf("walk_%0d", i), ifc.columnas_o, walk[i]);
      end

      // Single press on column 1 row 3, held long.
      keys[1*4+3] = 1'b1;
      wait_col(4'b1101, 20, "press1_col_seen", n);
      wait_pulse(0, 60, "press1_pulse");
      exp_pulses++;
      chk("press1_latency", pulse_cyc, n + 4 + 8);
      chk("press1_codc", pulse_codc, 2'd1);
      chk("press1_codf", pulse_codf, 2'd3);
      repeat (200) @(negedge clk);
      chk("press1_single", pulse_cnt, exp_pulses);
      chk("press1_col_held", ifc.columnas_o, 4'b1101);
      keys = '0;
      repeat (8) @(negedge clk);
      chk("release1_advance", ifc.columnas_o, 4'b1011);

      // Bouncing key on column 0: never stable long enough.
      wait_col(4'b1110, 20, "bounce_col0_seen", n);
      for (int i = 0; i < 10; i++) begin
         keys[0] = ~keys[0];
         repeat (3) @(negedge clk);
      end
      keys = '0;
      wait_col(4'b0111, 20, "bounce_scan_resumes", n);
      chk("bounce_no_pulse", pulse_cnt, exp_pulses);

      // Two rows low on column 0 are ignored and the column still advances after 4 cycles.
      keys[0] = 1'b1;
      keys[1] = 1'b1;
      wait_col(4'b1110, 20, "multi_col0_seen", n0);
      wait_col(4'b1101, 20, "multi_col1_seen", n1);
      chk("multi_dwell", n1 - n0, 4);
      chk("multi_no_pulse", pulse_cnt, exp_pulses);
      keys = '0;

      // Second key: codes hold the previous value until the new pulse.
      chk("hold_codc", ifc.dato_codc_o, 2'd1);
      chk("hold_codf", ifc.dato_codf_o, 2'd3);
      keys[2*4+1] = 1'b1;
      wait_pulse(pulse_cnt, 60, "press2_pulse");
      exp_pulses++;
      chk("press2_codc", pulse_codc, 2'd2);
      chk("press2_codf", pulse_codf, 2'd1);
      repeat (30) @(negedge clk);
      chk("press2_single", pulse_cnt, exp_pulses);
      keys = '0;
      repeat (10) @(negedge clk);

      // Reset in the 4th debounce cycle discards the pending press.
      wait_col(4'b1110, 20, "rstdb_col0_seen", n);
      keys[3*4+2] = 1'b1;
      wait_col(4'b0111, 20, "rstdb_col3_seen", n);
      repeat (7) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstdb_columnas", ifc.columnas_o, 4'b1110);
      chk("rstdb_listo", ifc.dato_listo_o, 1'b0);
      chk("rstdb_codc", ifc.dato_codc_o, 2'd0);
      keys = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("rstdb_no_pulse", pulse_cnt, exp_pulses);

      // Random keys: one key down -> exactly one pulse with its coordinates; two rows -> none.
      for (int it = 0; it < 8; it++) begin
         c = $urandom_range(0, 3);
         r = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) begin
            r2 = (r + 1 + $urandom_range(0, 2)) % 4;
            keys[c*4+r]  = 1'b1;
            keys[c*4+r2] = 1'b1;
            repeat (40) @(negedge clk);
            chk($sformatf("rand%0d_multi_none", it), pulse_cnt, exp_pulses);
            keys = '0;
            repeat (4) @(negedge clk);
         end else begin
            keys[c*4+r] = 1'b1;
            wait_pulse(exp_pulses, 60, $sformatf("rand%0d_pulse", it));
            exp_pulses++;
            chk($sformatf("rand%0d_codc", it), pulse_codc, c);
            chk($sformatf("rand%0d_codf", it), pulse_codf, r);
            repeat ($urandom_range(5, 40)) @(negedge clk);
            chk($sformatf("rand%0d_single", it), pulse_cnt, exp_pulses);
            keys = '0;
            repeat (12) @(negedge clk);
         end
      end

      chk("codes_change_only_on_pulse", glitch_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/module_teclado_scan.md
# module_teclado_scan

Matrix keypad scanner and debouncer for the multiplier front end. It drives the 4 keypad columns one at a time (active-low) and samples the 4 pulled-up rows. A key press must be single and stable before it is accepted. Each accepted press produces a 2-bit column code, a 2-bit row code and a one-cycle `dato_listo_o` pulse, consumed directly by `module_dato`.

## Interface
- `SCAN_CYCLES`, default 1000: clock cycles each column stays driven before rows are sampled; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a press or a release; must be ≥ 1.
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-low reset.
- `filas_i`, input, 4: keypad rows; bit i low means row i is conducting.
- `columnas_o`, output, 4: column drive; exactly one bit is low, and bit j low selects column j.
- `dato_codc_o`, output, 2: column code of the last accepted key.
- `dato_codf_o`, output, 2: row code of the last accepted key.
- `dato_listo_o`, output, 1: one-cycle pulse marking the cycle the codes are updated.

## Operation
- **FSM states:** SCAN, DEBOUNCE, PRESS, WAIT_RELEASE.
- **SCAN:**
  - A counter runs 0 to SCAN_CYCLES−1 with the current column held.
  - At count SCAN_CYCLES−1, if exactly one row bit is low, latch the column index and row index (0–3) and go to DEBOUNCE.
  - Otherwise advance the column (3 wraps to 0), reset the counter and stay in SCAN.
- **DEBOUNCE:**
  - The column is held.
  - Each cycle the row pattern must equal the latched one-hot-low pattern.
  - A mismatch returns to SCAN on the same column with the counter at 0, and no pulse is issued.
  - After DEBOUNCE_CYCLES matching cycles, go to PRESS.
- **PRESS** (one cycle):
  - `dato_codc_o` and `dato_codf_o` load the latched indices and `dato_listo_o` = 1.
  - Go to WAIT_RELEASE.
- **WAIT_RELEASE:**
  - The column is held.
  - Count consecutive cycles with `filas_i` = 4'b1111; any low row resets the count.
  - When the count reaches DEBOUNCE_CYCLES, advance the column and go to SCAN.
  - A held key never produces a second pulse.
- **Multiple rows low** at the sample point: treated as no key, and scanning continues.
- **Keys on other columns** pressed while in DEBOUNCE or WAIT_RELEASE are ignored.
- **Output hold:** the codes keep their last accepted value between presses; the consumer samples them only when the pulse is high.
- **Counter width:** $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES) + 1); counters saturate, they do not wrap.

## Timing
- **Reset values:** `columnas_o` = 4'b1110, `dato_codc_o` = 0, `dato_codf_o` = 0, `dato_listo_o` = 0, state SCAN, counters 0.
- **Reset mid-operation:** takes effect on the next edge from any state; a pending press is discarded with no pulse.
- **Outputs:** all are registered.
- **Press latency:** `dato_listo_o` is high in the (DEBOUNCE_CYCLES+1)th cycle after the qualifying SCAN sample edge, plus 2 cycles when the synchronizer is compiled in.
- **Pulse width:** exactly 1 cycle, with the codes valid in that same cycle.
- **Full column scan period:** 4·SCAN_CYCLES cycles when idle.

## Configuration
- **Macro:** `TECLADO_SYNC_EN`.
- **Defined:** `filas_i` passes through a 2-flop synchronizer, reset to 4'b1111, before all FSM logic; this adds 2 cycles of latency.
- **Undefined:** `filas_i` is used directly. This is for simulation and benches that drive synchronous stimulus only.

## Structure
- **Package `teclado_pkg`:**
  - state enum `teclado_state_t` (SCAN, DEBOUNCE, PRESS, WAIT_RELEASE)
  - `NUM_COLS` = 4, `NUM_ROWS` = 4
  - `FILAS_IDLE` = 4'b1111
  - `COL_RESET` = 4'b1110
- **Sub-module `module_sync_2ff`:** parameterized width; instantiated only under `TECLADO_SYNC_EN`.

## Test plan
All scenarios use bench parameters SCAN_CYCLES = 4 and DEBOUNCE_CYCLES = 8.
1. **Reset:** hold `rst` = 0 for 3 cycles → `columnas_o` = 4'b1110, codes 0, pulse 0; after release, the column walks 1110→1101→1011→0111→1110 every 4 cycles.
2. **Single press with hold:** drive `filas_i` = 4'b0111 whenever `columnas_o` = 4'b1101 and hold for 200 cycles → exactly one pulse with codc = 1 and codf = 3 (`module_dato` shows 0); no second pulse during the hold.
3. **Bounce:** toggle row 0 every 3 cycles for 30 cycles on column 0, then release → no pulse, and scanning resumes.
4. **Multiple rows:** `filas_i` = 4'b1100 on column 0 → no pulse, and the column advances to 4'b1101.
5. **Second key:** after release debounce, press column 2 row 1 (`filas_i` = 4'b1101) → single pulse with codc = 2 and codf = 1; the codes hold 1/3 until that pulse.
6. **Reset during DEBOUNCE:** assert reset in DEBOUNCE cycle 4 → the next edge gives `columnas_o` = 4'b1110 and no pulse is ever issued for that press.
